// File: rtl/alu_mult_seq.sv
// ---------------------------------------------------------------------------
// alu_mult_seq
//
// Sequential signed 32x32 multiplier.  It owns no adder of its own.  Every
// addition and subtraction goes through a shared external ALU: this block
// drives the ALU operands and opcode, and the ALU returns a combinational
// result in the same cycle.
//
// Operation:
//   1. NEG_A / NEG_B take the magnitudes of the operands (0 - x when x < 0).
//   2. ITER runs 32 shift-add steps on a 64-bit {hi,lo} accumulator.  lo
//      starts as |B|, and each step adds |A| to hi when lo[0] is set.
//   3. FIX re-applies the sign to the low word (0 +/- lo) and derives the
//      signed-32-bit overflow flag.
//   4. DONE pulses done for one cycle, then the block returns to IDLE.
//
// Handshake: start is sampled only on a rising edge where ready=1.  That edge
// drops ready, and start seen at any other time is ignored.  done is a
// one-cycle pulse.  data_result and overflow are registered and hold their
// values until the next completed multiply.
//
// Ports:
//   clock, reset_n            clock, async active-low reset
//   start                     request a multiply (sampled when ready=1)
//   data_operandA/B   [31:0]  two's complement operands
//   ready                     high only while idle
//   done                      one-cycle completion pulse
//   data_result       [31:0]  low 32 bits of the signed product
//   overflow                  product does not fit in signed 32 bits
//   alu_operandA/B    [31:0]  operands driven to the shared ALU
//   alu_opcode        [4:0]   5'd0 = ADD, 5'd1 = SUB
//   alu_shiftamt      [4:0]   always zero
//   alu_result        [31:0]  combinational ALU result for the current drive
// ---------------------------------------------------------------------------
module alu_mult_seq (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic        ready,
    output logic        done,
    output logic [31:0] data_result,
    output logic        overflow,
    output logic [31:0] alu_operandA,
    output logic [31:0] alu_operandB,
    output logic [4:0]  alu_opcode,
    output logic [4:0]  alu_shiftamt,
    input  logic [31:0] alu_result
);

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_NEG_A = 3'd1,
        S_NEG_B = 3'd2,
        S_ITER  = 3'd3,
        S_FIX   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t      r_state;
    logic [31:0] r_a_cap;
    logic [31:0] r_b_cap;
    logic        r_sign;
    logic [31:0] r_mag_a;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [4:0]  r_count;
    logic [31:0] r_result;
    logic        r_overflow;
    logic        r_ready;
    logic        r_done;

    logic        w_sign_eff;
    logic        w_fix_ovf;
    logic [63:0] w_iter_next;

    // A zero product is never negated, so -0 cannot come out as a negative sign.
    assign w_sign_eff = r_sign & ({r_hi, r_lo} != 64'd0);

    // A negative result may reach magnitude 2^31, because -2^31 still fits.
    // A positive result must stay below 2^31.
    assign w_fix_ovf = (r_hi != 32'd0) |
                       (w_sign_eff ? (r_lo > 32'h8000_0000) : r_lo[31]);

    // The hi-word sum never carries out (hi < 2^31 and |A| <= 2^31).  A plain
    // 64-bit logical shift of {sum, lo} is therefore a complete step.
    assign w_iter_next = {alu_result, r_lo} >> 1;

    // ALU drive is combinational from state so alu_result is usable this cycle.
    always_comb begin
        alu_operandA = 32'd0;
        alu_operandB = 32'd0;
        alu_opcode   = OP_ADD;
        case (r_state)
            S_NEG_A: begin
                alu_operandB = r_a_cap;
                alu_opcode   = OP_SUB;
            end
            S_NEG_B: begin
                alu_operandB = r_b_cap;
                alu_opcode   = OP_SUB;
            end
            S_ITER: begin
                alu_operandA = r_hi;
                alu_operandB = r_lo[0] ? r_mag_a : 32'd0;
                alu_opcode   = OP_ADD;
            end
            S_FIX: begin
                alu_operandB = r_lo;
                alu_opcode   = w_sign_eff ? OP_SUB : OP_ADD;
            end
            default: begin
                alu_operandA = 32'd0;
                alu_operandB = 32'd0;
                alu_opcode   = OP_ADD;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_a_cap    <= 32'd0;
            r_b_cap    <= 32'd0;
            r_sign     <= 1'b0;
            r_mag_a    <= 32'd0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_count    <= 5'd0;
            r_result   <= 32'd0;
            r_overflow <= 1'b0;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_cap <= data_operandA;
                        r_b_cap <= data_operandB;
                        r_sign  <= data_operandA[31] ^ data_operandB[31];
                        r_ready <= 1'b0;
                        r_state <= S_NEG_A;
                    end
                end
                S_NEG_A: begin
                    // 0 - 0x80000000 wraps to 0x80000000, which is |-2^31| as unsigned.
                    r_mag_a <= r_a_cap[31] ? alu_result : r_a_cap;
                    r_state <= S_NEG_B;
                end
                S_NEG_B: begin
                    r_lo    <= r_b_cap[31] ? alu_result : r_b_cap;
                    r_hi    <= 32'd0;
                    r_count <= 5'd0;
                    r_state <= S_ITER;
                end
                S_ITER: begin
                    r_hi    <= w_iter_next[63:32];
                    r_lo    <= w_iter_next[31:0];
                    r_count <= r_count + 5'd1;
                    if (r_count == 5'd31) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_result   <= alu_result;
                    r_overflow <= w_fix_ovf;
                    r_done     <= 1'b1;
                    r_state    <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready        = r_ready;
    assign done         = r_done;
    assign data_result  = r_result;
    assign overflow     = r_overflow;
    assign alu_shiftamt = 5'd0;

endmodule
